// File: rtl/debugger_protocol_pkg.sv
// Shared constants and state encoding for the debugger host command processor.
// Opcodes arrive from the host; response codes go back with bit 7 set.
package debugger_protocol_pkg;

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_PING   = 8'h03;

  localparam logic [7:0] RSP_READ  = 8'h81;
  localparam logic [7:0] RSP_WRITE = 8'h82;
  localparam logic [7:0] RSP_PING  = 8'h83;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_HI,
    ST_ID_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/debugger_protocol.sv
// Host command processor: parses framed READ/WRITE/PING commands from the debug UART,
// performs one value-bus access per command and serialises the response back.
module debugger_protocol
  import debugger_protocol_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_values_ena,
  output logic        o_values_wea,
  output logic [15:0] o_values_id,
  output logic [15:0] o_values_data,
  input  logic [15:0] i_values_data,
  output logic        o_rx_overrun,
  output logic        o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [7:0]       opcode;
  logic [CNT_W-1:0] idle_cnt;
  logic [1:0]       byte_idx;
  logic [1:0]       last_idx;
  logic [7:0]       resp_b1;
  logic [7:0]       resp_b2;
  logic             waiting;
  logic             busy;

  assign waiting = (state == ST_ID_HI) || (state == ST_ID_LO) ||
                   (state == ST_DATA_HI) || (state == ST_DATA_LO);
  assign busy    = (state == ST_ACCESS) || (state == ST_RESP);

  // A received byte always takes priority over an expiring timeout in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      opcode        <= 8'h00;
      idle_cnt      <= '0;
      byte_idx      <= 2'd0;
      last_idx      <= 2'd0;
      resp_b1       <= 8'h00;
      resp_b2       <= 8'h00;
      o_tx_valid    <= 1'b0;
      o_tx_data     <= 8'h00;
      o_values_ena  <= 1'b0;
      o_values_wea  <= 1'b0;
      o_values_id   <= 16'h0000;
      o_values_data <= 16'h0000;
      o_rx_overrun  <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_rx_overrun <= i_rx_valid && busy;
      o_timeout    <= 1'b0;

      if (waiting) begin
        if (i_rx_valid) begin
          idle_cnt <= '0;
        end else if (idle_cnt == CNT_MAX) begin
          o_timeout <= 1'b1;
          state     <= ST_IDLE;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            opcode   <= i_rx_data;
            idle_cnt <= '0;
            byte_idx <= 2'd0;
            case (i_rx_data)
              OP_READ, OP_WRITE: state <= ST_ID_HI;
              OP_PING: begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= RSP_PING;
                last_idx   <= 2'd0;
                state      <= ST_RESP;
              end
              default: begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= RSP_ERR;
                resp_b1    <= i_rx_data;
                last_idx   <= 2'd1;
                state      <= ST_RESP;
              end
            endcase
          end
        end
        ST_ID_HI: begin
          if (i_rx_valid) begin
            o_values_id[15:8] <= i_rx_data;
            state             <= ST_ID_LO;
          end
        end
        ST_ID_LO: begin
          if (i_rx_valid) begin
            o_values_id[7:0] <= i_rx_data;
            if (opcode == OP_WRITE) begin
              state <= ST_DATA_HI;
            end else begin
              o_values_ena <= 1'b1;
              o_values_wea <= 1'b0;
              state        <= ST_ACCESS;
            end
          end
        end
        ST_DATA_HI: begin
          if (i_rx_valid) begin
            o_values_data[15:8] <= i_rx_data;
            state               <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (i_rx_valid) begin
            o_values_data[7:0] <= i_rx_data;
            o_values_ena       <= 1'b1;
            o_values_wea       <= 1'b1;
            state              <= ST_ACCESS;
          end
        end
        // Read data is only valid while the strobe is up, so capture it here.
        ST_ACCESS: begin
          o_values_ena <= 1'b0;
          o_values_wea <= 1'b0;
          resp_b1      <= i_values_data[15:8];
          resp_b2      <= i_values_data[7:0];
          byte_idx     <= 2'd0;
          o_tx_valid   <= 1'b1;
          if (o_values_wea) begin
            o_tx_data <= RSP_WRITE;
            last_idx  <= 2'd0;
          end else begin
            o_tx_data <= RSP_READ;
            last_idx  <= 2'd2;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (o_tx_valid && i_tx_ready) begin
            if (byte_idx == last_idx) begin
              o_tx_valid <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              byte_idx  <= byte_idx + 2'd1;
              o_tx_data <= (byte_idx == 2'd0) ? resp_b1 : resp_b2;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/debugger_protocol.md
# debugger_protocol

Host-side command processor for the NES debugger. It sits between the debug UART (RX byte strobe in, TX byte handshake out) and the debugger value register bank. It parses framed read and write commands from the host, issues single-cycle accesses on the value bus, and serialises responses back to the host. All CPU stepping and inspection traffic from the host passes through this block.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1_000_000: number of idle cycles allowed inside a partially received command before it is abandoned.

Ports:
- i_clk, in, 1: clock.
- i_reset_n, in, 1: asynchronous, active-low reset.
- i_rx_valid, in, 1: one-cycle strobe marking a received byte; there is no backpressure.
- i_rx_data, in, 8: received byte, valid while i_rx_valid is high.
- o_tx_valid, out, 1: response byte available.
- o_tx_data, out, 8: response byte.
- i_tx_ready, in, 1: UART TX accepts the byte on a cycle where both valid and ready are high.
- o_values_ena, out, 1: value bus access strobe.
- o_values_wea, out, 1: value bus write enable; only meaningful while o_values_ena is high.
- o_values_id, out, 16: value ID.
- o_values_data, out, 16: write data.
- i_values_data, in, 16: read data; combinational from the bank while o_values_ena is high.
- o_rx_overrun, out, 1: one-cycle pulse when an RX byte is dropped.
- o_timeout, out, 1: one-cycle pulse when a partial command is abandoned.

## Operation
Commands use big-endian multi-byte fields:
- READ: 0x01, id_hi, id_lo. Response: 0x81, data_hi, data_lo.
- WRITE: 0x02, id_hi, id_lo, d_hi, d_lo. Response: 0x82.
- PING: 0x03. Response: 0x83. No bus access is made.
- Any other opcode received in IDLE: response 0xEE followed by the offending opcode. No bus access is made.

FSM states: IDLE, ID_HI, ID_LO, DATA_HI, DATA_LO, ACCESS, RESP.
- IDLE: on an RX byte, latch the opcode.
  - READ or WRITE: go to ID_HI.
  - PING or unknown opcode: go to RESP.
- ID_HI → ID_LO: shift in id_hi.
- ID_LO, after id_lo arrives:
  - READ: go to ACCESS.
  - WRITE: go to DATA_HI.
- DATA_HI → DATA_LO → ACCESS: shift in the two data bytes.
- ACCESS lasts exactly one cycle:
  - o_values_ena = 1.
  - o_values_wea = 1 for WRITE, 0 for READ.
  - For READ, i_values_data is captured into the response register at the end of this cycle.
  - Next state is RESP.
- RESP: a 2-bit byte index walks through the response bytes (1, 2 or 3 bytes). The index advances on each valid&&ready cycle. After the last byte is accepted, the FSM returns to IDLE.

Boundary conditions:
- **RX during ACCESS or RESP:** the byte is dropped, o_rx_overrun pulses, and the FSM is unaffected.
- **Timeout:** a counter runs in ID_HI through DATA_LO and clears on every RX byte. On reaching TIMEOUT_CYCLES-1 without a byte, the FSM goes to IDLE and o_timeout pulses. No bus access and no response are produced. Counter width is $clog2(TIMEOUT_CYCLES).
- **i_rx_valid on the same cycle the timeout fires:** the byte wins. It is consumed normally and no timeout occurs.
- **Reset mid-command or mid-response:** the FSM returns to IDLE and the partial command is discarded.
- **Register state after a transaction:** o_values_id and o_values_data hold their last values. Only o_values_ena and o_values_wea return to 0.

## Timing
- Reset values: o_tx_valid=0, o_tx_data=0x00, o_values_ena=0, o_values_wea=0, o_values_id=0, o_values_data=0, o_rx_overrun=0, o_timeout=0, state=IDLE.
- Final command byte strobed at edge N: o_values_ena is high during cycle N..N+1. o_tx_valid rises after edge N+1 carrying the first response byte.
- PING or unknown opcode at edge N: o_tx_valid rises after edge N. There is no ACCESS cycle.
- TX handshake rules:
  - o_tx_data is stable while o_tx_valid && !i_tx_ready.
  - Successive response bytes are presented on the cycle after each acceptance; o_tx_valid stays high through the response.
  - o_tx_valid drops on the cycle after the last byte is accepted.
- Accepted turnaround: IDLE is re-entered one cycle after the last TX acceptance, and a new command byte is accepted from that cycle onward.
- All outputs are registered.

## Structure
- debugger_protocol_pkg holds:
  - opcode constants: 0x01, 0x02, 0x03.
  - response constants: 0x81, 0x82, 0x83, 0xEE.
  - the state enum.
- No sub-module. The timeout counter and response serialiser are small and tightly coupled to the FSM, so both are inline.

## Test plan
- **READ:** RX 0x01,0x00,0x08 with i_values_data=0x0042 → one ena cycle with wea=0 and id=0x0008; TX 0x81,0x00,0x42.
- **WRITE:** RX 0x02,0x00,0x01,0x00,0x01 → one ena cycle with wea=1, id=0x0001, data=0x0001; TX 0x82.
- **Unknown opcode and PING:** RX 0x7F → TX 0xEE,0x7F with no ena. RX 0x03 → TX 0x83.
- **TX backpressure:** READ with i_tx_ready low for 5 cycles per byte → o_tx_data held stable; three bytes delivered in order with no duplicates.
- **Overrun and timeout:** RX 0x01 then silence (TIMEOUT_CYCLES=16) → o_timeout pulses once after 16 idle cycles; a following PING is answered normally. RX byte during RESP → o_rx_overrun pulses and the response is unchanged.
- **Reset mid-WRITE:** i_reset_n asserted after the id bytes → all outputs return to reset values; a subsequent full READ completes correctly.
